// File: rtl/rc_cpl_pkg.sv
// rc_cpl_pkg -- shared definitions for the Requester Completion receiver.
//   * Absolute bit offsets of the completion descriptor fields within the
//     first 128-bit beat of an RC packet (DW0 = bits [31:0]).
//   * Receiver state encoding.
//   * Completion status codes.
//   * keep_from_rem(): dword keep mask for the remaining payload length.
package rc_cpl_pkg;

  localparam int DESC_ERR_CODE_LO  = 12;  // DW0[15:12]
  localparam int DESC_BYTE_CNT_LO  = 16;  // DW0[28:16]
  localparam int DESC_REQ_DONE_BIT = 30;  // DW0[30]
  localparam int DESC_DW_CNT_LO    = 32;  // DW1[10:0]
  localparam int DESC_STATUS_LO    = 43;  // DW1[13:11]
  localparam int DESC_POISON_BIT   = 46;  // DW1[14]
  localparam int DESC_TAG_LO       = 64;  // DW2[7:0]
  localparam int DESC_DW3_LO       = 96;  // DW3, first payload dword

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_FLUSH,
    ST_DROP
  } rx_state_e;

  typedef enum logic [2:0] {
    CPL_SC  = 3'd0,
    CPL_UR  = 3'd1,
    CPL_CRS = 3'd2,
    CPL_CA  = 3'd4
  } cpl_status_e;

  // Low min(rem,4) bits set.
  function automatic logic [3:0] keep_from_rem(input logic [10:0] rem);
    logic [3:0] k;
    k = 4'b0000;
    if (rem >= 11'd4)      k = 4'b1111;
    else if (rem == 11'd3) k = 4'b0111;
    else if (rem == 11'd2) k = 4'b0011;
    else if (rem == 11'd1) k = 4'b0001;
    return k;
  endfunction

endpackage

// File: rtl/rc_cpl_rx.sv
// rc_cpl_rx -- PCIe Requester Completion receiver.
// Decodes the descriptor on the first beat of each RC packet into hdr_*
// (one-cycle hdr_valid pulse, no backpressure) and realigns the payload,
// which starts in DW3 of the descriptor beat, so that payload DW0 lands in
// out_data[31:0]. Length mismatches pulse err_len and bump err_count.
// Ports:
//   user_clk, reset            clock, synchronous active-high reset
//   m_axis_rc_*                RC stream in (tready is our backpressure)
//   hdr_*                      descriptor fields, valid with hdr_valid
//   out_data/keep/last/valid   realigned payload, out_ready from sink
//   out_tag                    tag owning the current out beat
//   err_len                    length error pulse
//   cpl_count, err_count       completions accepted / length errors
module rc_cpl_rx
  import rc_cpl_pkg::*;
#(
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RC_TUSER_WIDTH = 75
) (
  input  logic                           user_clk,
  input  logic                           reset,
  input  logic [C_DATA_WIDTH-1:0]        m_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0]          m_axis_rc_tkeep,
  input  logic                           m_axis_rc_tlast,
  input  logic                           m_axis_rc_tvalid,
  input  logic [AXI4_RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
  output logic                           m_axis_rc_tready,
  output logic                           hdr_valid,
  output logic [7:0]                     hdr_tag,
  output logic [2:0]                     hdr_status,
  output logic [3:0]                     hdr_err_code,
  output logic [12:0]                    hdr_byte_count,
  output logic [10:0]                    hdr_dw_count,
  output logic                           hdr_req_done,
  output logic                           hdr_poisoned,
  output logic [C_DATA_WIDTH-1:0]        out_data,
  output logic [KEEP_WIDTH-1:0]          out_keep,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_tag,
  output logic                           err_len,
  output logic [15:0]                    cpl_count,
  output logic [15:0]                    err_count
);

  rx_state_e   state, state_next;
  logic [31:0] held;
  logic [10:0] rem;

  logic        rc_ready, rc_fire, out_free;
  logic        desc_take, data_take, flush_take, len_err, force_last;
  logic [10:0] desc_dw;

  // tuser is ignored; most descriptor bits are reserved for this block.
  logic unused_inputs;
  assign unused_inputs = ^{m_axis_rc_tuser, m_axis_rc_tkeep, m_axis_rc_tdata};

  assign desc_dw          = m_axis_rc_tdata[DESC_DW_CNT_LO +: 11];
  assign out_free         = !out_valid || out_ready;
  assign rc_fire          = m_axis_rc_tvalid && rc_ready;
  assign m_axis_rc_tready = rc_ready;

  always_ff @(posedge user_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rc_ready   = 1'b0;
    desc_take  = 1'b0;
    data_take  = 1'b0;
    flush_take = 1'b0;
    len_err    = 1'b0;
    force_last = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rc_ready = 1'b1;
        if (rc_fire) begin
          desc_take = 1'b1;
          if (desc_dw == 11'd0) begin
            state_next = ST_IDLE;
          end else if (m_axis_rc_tlast) begin
            if (desc_dw == 11'd1) state_next = ST_FLUSH;
            else begin
              len_err    = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        rc_ready = out_free;
        if (rc_fire) begin
          data_take = 1'b1;
          if (rem <= 11'd4) begin
            state_next = m_axis_rc_tlast ? ST_IDLE : ST_DROP;
          end else if (m_axis_rc_tlast) begin
            // Packet ends early; only legal if exactly one dword (the new
            // held DW3) is still owed and it is actually present.
            if (rem == 11'd5 && m_axis_rc_tkeep[3]) begin
              state_next = ST_FLUSH;
            end else begin
              force_last = 1'b1;
              len_err    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          flush_take = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        rc_ready = 1'b1;
        if (rc_fire && m_axis_rc_tlast) begin
          len_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      hdr_valid      <= 1'b0;
      hdr_tag        <= '0;
      hdr_status     <= '0;
      hdr_err_code   <= '0;
      hdr_byte_count <= '0;
      hdr_dw_count   <= '0;
      hdr_req_done   <= 1'b0;
      hdr_poisoned   <= 1'b0;
      out_data       <= '0;
      out_keep       <= '0;
      out_last       <= 1'b0;
      out_valid      <= 1'b0;
      out_tag        <= '0;
      err_len        <= 1'b0;
      cpl_count      <= '0;
      err_count      <= '0;
      held           <= '0;
      rem            <= '0;
    end else begin
      hdr_valid <= desc_take;
      err_len   <= len_err;
      if (len_err) err_count <= err_count + 16'd1;

      if (desc_take) begin
        hdr_tag        <= m_axis_rc_tdata[DESC_TAG_LO +: 8];
        hdr_status     <= m_axis_rc_tdata[DESC_STATUS_LO +: 3];
        hdr_err_code   <= m_axis_rc_tdata[DESC_ERR_CODE_LO +: 4];
        hdr_byte_count <= m_axis_rc_tdata[DESC_BYTE_CNT_LO +: 13];
        hdr_dw_count   <= desc_dw;
        hdr_req_done   <= m_axis_rc_tdata[DESC_REQ_DONE_BIT];
        hdr_poisoned   <= m_axis_rc_tdata[DESC_POISON_BIT];
        cpl_count      <= cpl_count + 16'd1;
        held           <= m_axis_rc_tdata[DESC_DW3_LO +: 32];
        rem            <= desc_dw;
      end

      if (data_take) begin
        out_data  <= {m_axis_rc_tdata[95:0], held};
        out_keep  <= keep_from_rem(rem);
        out_last  <= (rem <= 11'd4) || force_last;
        out_tag   <= hdr_tag;
        out_valid <= 1'b1;
        held      <= m_axis_rc_tdata[DESC_DW3_LO +: 32];
        rem       <= (rem > 11'd4) ? rem - 11'd4 : 11'd0;
      end else if (flush_take) begin
        out_data  <= {96'b0, held};
        out_keep  <= 4'b0001;
        out_last  <= 1'b1;
        out_tag   <= hdr_tag;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc_cpl_rx.sv
// tb_rc_cpl_rx -- directed bench for rc_cpl_rx: a per-cycle vector table
// for the single-stream cases, then hand sequences for backpressure and
// mid-packet reset.
module tb_rc_cpl_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic         tlast, tvalid;
  logic [74:0]  tuser;
  logic         tready;
  logic         hdr_valid;
  logic [7:0]   hdr_tag;
  logic [2:0]   hdr_status;
  logic [3:0]   hdr_err_code;
  logic [12:0]  hdr_byte_count;
  logic [10:0]  hdr_dw_count;
  logic         hdr_req_done, hdr_poisoned;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last, out_valid, out_ready;
  logic [7:0]   out_tag;
  logic         err_len;
  logic [15:0]  cpl_count, err_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  rc_cpl_rx #(.C_DATA_WIDTH(128), .KEEP_WIDTH(4), .AXI4_RC_TUSER_WIDTH(75)) dut (
    .user_clk(clk), .reset(reset),
    .m_axis_rc_tdata(tdata), .m_axis_rc_tkeep(tkeep), .m_axis_rc_tlast(tlast),
    .m_axis_rc_tvalid(tvalid), .m_axis_rc_tuser(tuser), .m_axis_rc_tready(tready),
    .hdr_valid(hdr_valid), .hdr_tag(hdr_tag), .hdr_status(hdr_status),
    .hdr_err_code(hdr_err_code), .hdr_byte_count(hdr_byte_count),
    .hdr_dw_count(hdr_dw_count), .hdr_req_done(hdr_req_done), .hdr_poisoned(hdr_poisoned),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .err_len(err_len),
    .cpl_count(cpl_count), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] desc(input logic [7:0] tag, input logic [10:0] dw,
                                        input logic [2:0] st, input logic [31:0] d3,
                                        input logic pois, input logic [3:0] ec);
    logic [31:0] w0, w1, w2;
    w0 = '0;
    w0[15:12] = ec;
    w0[28:16] = {dw, 2'b00};
    w0[30] = 1'b1;
    w1 = {17'b0, pois, st, dw};
    w2 = {24'b0, tag};
    return {d3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] bt(input logic [31:0] d3, input logic [31:0] d2,
                                      input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  typedef struct {
    logic         vld;
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic         e_trdy;
    logic         e_hv;
    logic [7:0]   e_htag;
    logic [2:0]   e_hst;
    logic         e_ov;
    logic [127:0] e_od;
    logic [3:0]   e_ok;
    logic         e_ol;
    logic [7:0]   e_otag;
    logic         e_err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic vld, input logic [127:0] data, input logic [3:0] keep,
                              input logic last, input logic e_trdy, input logic e_hv,
                              input logic [7:0] e_htag, input logic [2:0] e_hst,
                              input logic e_ov, input logic [127:0] e_od, input logic [3:0] e_ok,
                              input logic e_ol, input logic [7:0] e_otag, input logic e_err);
    vec_t v;
    v.vld = vld; v.data = data; v.keep = keep; v.last = last;
    v.e_trdy = e_trdy; v.e_hv = e_hv; v.e_htag = e_htag; v.e_hst = e_hst;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ok = e_ok; v.e_ol = e_ol; v.e_otag = e_otag;
    v.e_err = e_err;
    vq.push_back(v);
  endfunction

  task automatic chk_zero(input string ctx);
    chk({ctx, " tready"}, 128'(tready), 128'(1));
    chk({ctx, " hdr_valid"}, 128'(hdr_valid), 128'(0));
    chk({ctx, " hdr_fields"}, 128'({hdr_tag, hdr_status, hdr_err_code, hdr_byte_count,
                                    hdr_dw_count, hdr_req_done, hdr_poisoned}), 128'(0));
    chk({ctx, " out_valid"}, 128'(out_valid), 128'(0));
    chk({ctx, " out_data"}, out_data, 128'(0));
    chk({ctx, " out_keep_last_tag"}, 128'({out_keep, out_last, out_tag}), 128'(0));
    chk({ctx, " err_len"}, 128'(err_len), 128'(0));
    chk({ctx, " counts"}, 128'({cpl_count, err_count}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] b[5];
    logic [127:0] exp_b[4];
    logic [127:0] prev;
    logic         stalled, fire_in, fire_out;
    int           bi, got;

    reset = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    tuser = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    //  vld data                                   keep     lst trdy hv htag st  ov od                               ok       ol otag err
    add(1, desc(8'h05, 11'd1, 3'd0, 32'hDEADBEEF, 0, 0), 4'hF, 1, 1, 1, 8'h05, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(0, '0,                                      4'h0, 0, 0, 0, 8'h00, 3'd0, 1, 128'hDEADBEEF, 4'h1, 1, 8'h05, 0);
    add(1, desc(8'h22, 11'd0, 3'd1, 32'h0, 0, 0),   4'hF, 1, 1, 1, 8'h22, 3'd1, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, desc(8'h31, 11'd8, 3'd0, 32'h0, 0, 0),   4'hF, 0, 1, 1, 8'h31, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, bt(4, 3, 2, 1),                          4'hF, 0, 1, 0, 8'h00, 3'd0, 1, bt(3, 2, 1, 0), 4'hF, 0, 8'h31, 0);
    add(1, bt(0, 7, 6, 5),                          4'h7, 1, 1, 0, 8'h00, 3'd0, 1, bt(7, 6, 5, 4), 4'hF, 1, 8'h31, 0);
    add(1, desc(8'h40, 11'd8, 3'd0, 32'h100, 0, 0), 4'hF, 0, 1, 1, 8'h40, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, bt(32'h104, 32'h103, 32'h102, 32'h101),  4'hF, 1, 1, 0, 8'h00, 3'd0, 1,
        bt(32'h103, 32'h102, 32'h101, 32'h100), 4'hF, 1, 8'h40, 1);
    add(1, desc(8'h41, 11'd1, 3'd0, 32'hCAFE0001, 0, 0), 4'hF, 1, 1, 1, 8'h41, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(0, '0,                                      4'h0, 0, 0, 0, 8'h00, 3'd0, 1, 128'hCAFE0001, 4'h1, 1, 8'h41, 0);
    add(0, '0,                                      4'h0, 0, 1, 0, 8'h00, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, desc(8'h50, 11'd5, 3'd0, 32'hA0, 0, 0),  4'hF, 0, 1, 1, 8'h50, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, bt(32'hA4, 32'hA3, 32'hA2, 32'hA1),      4'hF, 1, 1, 0, 8'h00, 3'd0, 1,
        bt(32'hA3, 32'hA2, 32'hA1, 32'hA0), 4'hF, 0, 8'h50, 0);
    add(0, '0,                                      4'h0, 0, 0, 0, 8'h00, 3'd0, 1, 128'hA4, 4'h1, 1, 8'h50, 0);
    add(1, desc(8'h60, 11'd2, 3'd0, 32'hB0, 0, 0),  4'hF, 0, 1, 1, 8'h60, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, bt(32'hB4, 32'hB3, 32'hB2, 32'hB1),      4'hF, 0, 1, 0, 8'h00, 3'd0, 1,
        bt(32'hB3, 32'hB2, 32'hB1, 32'hB0), 4'h3, 1, 8'h60, 0);
    add(1, bt(32'hC4, 32'hC3, 32'hC2, 32'hC1),      4'hF, 0, 1, 0, 8'h00, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);
    add(1, bt(0, 0, 0, 0),                          4'hF, 1, 1, 0, 8'h00, 3'd0, 0, '0, 4'h0, 0, 8'h00, 1);
    add(0, '0,                                      4'h0, 0, 1, 0, 8'h00, 3'd0, 0, '0, 4'h0, 0, 8'h00, 0);

    foreach (vq[i]) begin
      tvalid = vq[i].vld; tdata = vq[i].data; tkeep = vq[i].keep; tlast = vq[i].last;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d tready", i), 128'(tready), 128'(vq[i].e_trdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d hdr_valid", i), 128'(hdr_valid), 128'(vq[i].e_hv));
      if (vq[i].e_hv)
        chk($sformatf("v%0d hdr_tag_status", i), 128'({hdr_tag, hdr_status}),
            128'({vq[i].e_htag, vq[i].e_hst}));
      chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vq[i].e_ov));
      if (vq[i].e_ov) begin
        chk($sformatf("v%0d out_data", i), out_data, vq[i].e_od);
        chk($sformatf("v%0d keep_last_tag", i), 128'({out_keep, out_last, out_tag}),
            128'({vq[i].e_ok, vq[i].e_ol, vq[i].e_otag}));
      end
      chk($sformatf("v%0d err_len", i), 128'(err_len), 128'(vq[i].e_err));
    end
    chk("table cpl_count", 128'(cpl_count), 128'(7));
    chk("table err_count", 128'(err_count), 128'(2));

    // 16-dword completion with out_ready toggling 1,0,1,0...
    b[0] = desc(8'h70, 11'd16, 3'd0, 32'h1000, 0, 0);
    for (int k = 0; k < 3; k++)
      b[k+1] = bt(32'h1000 + 4*k + 4, 32'h1000 + 4*k + 3, 32'h1000 + 4*k + 2, 32'h1000 + 4*k + 1);
    b[4] = bt(0, 32'h100F, 32'h100E, 32'h100D);
    for (int k = 0; k < 4; k++)
      exp_b[k] = bt(32'h1000 + 4*k + 3, 32'h1000 + 4*k + 2, 32'h1000 + 4*k + 1, 32'h1000 + 4*k);
    bi = 0; got = 0; stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 200 && (bi < 5 || got < 4); cyc++) begin
      out_ready = (cyc % 2 == 0);
      tvalid = (bi < 5);
      tdata  = (bi < 5) ? b[bi] : '0;
      tlast  = (bi == 4);
      tkeep  = (bi == 4) ? 4'h7 : 4'hF;
      #1;
      if (stalled) begin
        chk("bp held valid", 128'(out_valid), 128'(1));
        chk("bp held data", out_data, prev);
      end
      if (bi >= 1 && bi <= 4 && out_valid && !out_ready)
        chk("bp tready low", 128'(tready), 128'(0));
      fire_in  = tvalid && tready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (got < 4) begin
          chk($sformatf("bp beat%0d data", got), out_data, exp_b[got]);
          chk($sformatf("bp beat%0d keep_last_tag", got), 128'({out_keep, out_last, out_tag}),
              128'({4'hF, (got == 3), 8'h70}));
        end else begin
          chk("bp extra beat", 128'(got), 128'(3));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
      @(posedge clk);
      #1;
      if (fire_in) bi++;
    end
    chk("bp beats in", 128'(bi), 128'(5));
    chk("bp beats out", 128'(got), 128'(4));
    chk("bp cpl_count", 128'(cpl_count), 128'(8));

    // Reset in the middle of a 16-dword completion
    tvalid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = desc(8'h7E, 11'd16, 3'd0, 32'h11, 0, 0); tkeep = 4'hF; tlast = 1'b0;
    @(posedge clk); #1;
    tdata = bt(32'h15, 32'h14, 32'h13, 32'h12);
    @(posedge clk); #1;
    chk("pre-reset out_valid", 128'(out_valid), 128'(1));
    tvalid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("midreset");
    tvalid = 1'b1; tdata = desc(8'h7A, 11'd1, 3'd0, 32'h12345678, 1, 4'h3); tlast = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    chk("post hdr_valid", 128'(hdr_valid), 128'(1));
    chk("post hdr fields", 128'({hdr_tag, hdr_status, hdr_err_code, hdr_byte_count,
                                 hdr_dw_count, hdr_req_done, hdr_poisoned}),
        128'({8'h7A, 3'd0, 4'h3, 13'd4, 11'd1, 1'b1, 1'b1}));
    chk("post cpl_count", 128'(cpl_count), 128'(1));
    @(posedge clk); #1;
    chk("post out_valid", 128'(out_valid), 128'(1));
    chk("post out_data", out_data, 128'h12345678);
    chk("post keep_last_tag", 128'({out_keep, out_last, out_tag}), 128'({4'h1, 1'b1, 8'h7A}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
